// File: rtl/regfile_stream_reader.sv
// Read-side sequencer: walks an address range on a register-file read port and streams words out.
// Optional XOR checksum of streamed words: define REGFILE_STREAM_READER_CHECKSUM_EN.
module regfile_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic [ADDR_WIDTH-1:0] endAddr,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    input  logic [DATA_WIDTH-1:0] rdData,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [ADDR_WIDTH-1:0] outAddr,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  done
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] next_addr;
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
`endif

    assign next_addr = ADDR_WIDTH'(cur_addr_q + 1'b1);

    // Next-state and registered-output decode; status flags follow the next state.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        rd_addr_d  = rd_addr_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                rd_addr_d = '0;
                if (start) begin
                    cur_addr_d = startAddr;
                    end_addr_d = endAddr;
                    rd_addr_d  = startAddr;
                    state_d    = S_READ;
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            S_READ: begin
                out_data_d = rdData;
                out_addr_d = cur_addr_q;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (outReady) begin
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
                    checksum_d = checksum_q ^ out_data_q;
`endif
                    if (cur_addr_q == end_addr_q) begin
                        rd_addr_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        cur_addr_d = next_addr;
                        rd_addr_d  = next_addr;
                        state_d    = S_READ;
                    end
                end
            end
            S_DONE: begin
                rd_addr_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            end_addr_q  <= '0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            end_addr_q  <= end_addr_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign rdAddr   = rd_addr_q;
    assign outData  = out_data_q;
    assign outAddr  = out_addr_q;
    assign outValid = out_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef REGFILE_STREAM_READER_CHECKSUM_EN
    assign checksum = checksum_q;
`endif

endmodule
